// File: rtl/shot_ctrl.sv
// rtl/shot_ctrl.sv - projectile FSM: launch from paddle centre, step toward row 0, retire on hit/miss
// Optional SHOT_AUTOFIRE_EN: held fire re-launches whenever the FSM returns to IDLE.
module shot_ctrl #(
  parameter int c_PlayerPaddleX = 29,
  parameter int c_PaddleHeight  = 4,
  parameter int c_ShotSpeed     = 625000,
  parameter int c_CooldownTicks = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Fire,
  input  logic [5:0] i_PaddleY,
  input  logic       i_Hit,
  input  logic [5:0] i_ColCountDiv,
  input  logic [5:0] i_RowCountDiv,
  output logic [5:0] o_ShotRow,
  output logic [5:0] o_ShotCol,
  output logic       o_ShotActive,
  output logic       o_Miss,
  output logic       o_DrawShot
);

  localparam int c_TickW = (c_ShotSpeed > 0) ? $clog2(c_ShotSpeed + 1) : 1;
  localparam logic [c_TickW-1:0] c_TickMax = c_TickW'(c_ShotSpeed);
  localparam int c_CoolW = (c_CooldownTicks > 1) ? $clog2(c_CooldownTicks) : 1;
  localparam logic [c_CoolW-1:0] c_CoolLast =
    (c_CooldownTicks > 0) ? c_CoolW'(c_CooldownTicks - 1) : '0;
  localparam logic [5:0] c_LaunchRow = 6'(c_PlayerPaddleX - 1);
  localparam logic [5:0] c_ColOffset = 6'(c_PaddleHeight / 2);

  typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

  state_t             r_State;
  logic [c_TickW-1:0] r_TickCnt;
  logic [c_CoolW-1:0] r_CoolCnt;
  logic               r_FireMeta;
  logic               r_FireSync;
  logic               r_FireSyncD;
  logic               w_FireEdge;
  logic               w_Launch;
  logic               w_Tick;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_FireMeta  <= 1'b0;
      r_FireSync  <= 1'b0;
      r_FireSyncD <= 1'b0;
    end else begin
      r_FireMeta  <= i_Fire;
      r_FireSync  <= r_FireMeta;
      r_FireSyncD <= r_FireSync;
    end
  end

  assign w_FireEdge = r_FireSync & ~r_FireSyncD;

`ifdef SHOT_AUTOFIRE_EN
  // Level launch; the edge term is already covered by the level.
  assign w_Launch = r_FireSync | w_FireEdge;
`else
  assign w_Launch = w_FireEdge;
`endif

  assign w_Tick = (r_TickCnt == c_TickMax);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State      <= IDLE;
      r_TickCnt    <= '0;
      r_CoolCnt    <= '0;
      o_ShotRow    <= '0;
      o_ShotCol    <= '0;
      o_ShotActive <= 1'b0;
      o_Miss       <= 1'b0;
      o_DrawShot   <= 1'b0;
    end else begin
      o_Miss     <= 1'b0;
      o_DrawShot <= o_ShotActive && (i_RowCountDiv == o_ShotRow) &&
                    (i_ColCountDiv == o_ShotCol);
      case (r_State)
        IDLE: begin
          if (w_Launch) begin
            o_ShotCol    <= i_PaddleY + c_ColOffset;
            o_ShotRow    <= c_LaunchRow;
            r_TickCnt    <= '0;
            o_ShotActive <= 1'b1;
            r_State      <= FLY;
          end
        end
        FLY: begin
          // A hit beats a same-cycle step or miss: row holds, no miss pulse.
          if (i_Hit) begin
            r_TickCnt    <= '0;
            r_CoolCnt    <= '0;
            o_ShotActive <= 1'b0;
            r_State      <= COOLDOWN;
          end else if (w_Tick) begin
            r_TickCnt <= '0;
            if (o_ShotRow == 6'd0) begin
              o_Miss       <= 1'b1;
              r_CoolCnt    <= '0;
              o_ShotActive <= 1'b0;
              r_State      <= COOLDOWN;
            end else begin
              o_ShotRow <= o_ShotRow - 6'd1;
            end
          end else begin
            r_TickCnt <= r_TickCnt + 1'b1;
          end
        end
        COOLDOWN: begin
          if (w_Tick) begin
            r_TickCnt <= '0;
            if (r_CoolCnt == c_CoolLast) r_State <= IDLE;
            else r_CoolCnt <= r_CoolCnt + 1'b1;
          end else begin
            r_TickCnt <= r_TickCnt + 1'b1;
          end
        end
        default: begin
          o_ShotActive <= 1'b0;
          r_State      <= IDLE;
        end
      endcase
    end
  end

endmodule
